// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide sequencer holding HI/LO, one bit per cycle.
// Build option: define MULDIV_SEQ_DIV_EN to include the restoring divider.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic [31:0] opnd;
    logic [63:0] acc;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] sum;
    logic [63:0] prod;

`ifdef MULDIV_SEQ_DIV_EN
    logic        neg_rem;
    logic [31:0] a_orig;
    logic [32:0] rem;
    logic [33:0] partial;
    logic [33:0] diff;
`endif

    assign busy = (state != IDLE);

    // op[0]=0 selects the signed variants; only those take magnitudes.
    always_comb begin
        sign_a = ~op[0] & A[31];
        sign_b = ~op[0] & B[31];
        mag_a  = sign_a ? -A : A;
        mag_b  = sign_b ? -B : B;
        sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        prod   = neg_res ? -acc : acc;
    end

`ifdef MULDIV_SEQ_DIV_EN
    // A borrow out of diff means the divisor did not fit: keep the shifted remainder.
    always_comb begin
        partial = {rem, acc[31]};
        diff    = partial - {2'b00, opnd};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
`ifdef MULDIV_SEQ_DIV_EN
            neg_rem  <= 1'b0;
            a_orig   <= 32'd0;
            rem      <= 33'd0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) HI <= wdata;
                    if (lo_we) LO <= wdata;
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= sign_a ^ sign_b;
                        cnt     <= 5'd0;
`ifdef MULDIV_SEQ_DIV_EN
                        neg_rem <= sign_a;
                        a_orig  <= A;
                        rem     <= 33'd0;
                        opnd    <= op[1] ? mag_b : mag_a;
                        acc     <= {32'd0, op[1] ? mag_a : mag_b};
                        state   <= RUN;
`else
                        opnd    <= mag_a;
                        acc     <= {32'd0, mag_b};
                        state   <= op[1] ? FIX : RUN;
`endif
                    end
                end
                RUN: begin
`ifdef MULDIV_SEQ_DIV_EN
                    if (is_div) begin
                        rem        <= diff[33] ? partial[32:0] : diff[32:0];
                        acc[31:0]  <= {acc[30:0], ~diff[33]};
                    end else begin
                        acc <= {sum, acc[31:1]};
                    end
`else
                    acc <= {sum, acc[31:1]};
`endif
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
`ifdef MULDIV_SEQ_DIV_EN
                    if (is_div) begin
                        if (opnd == 32'd0) begin
                            HI       <= a_orig;
                            LO       <= 32'hFFFF_FFFF;
                            div_zero <= 1'b1;
                        end else begin
                            LO <= neg_res ? -acc[31:0] : acc[31:0];
                            HI <= neg_rem ? -rem[31:0] : rem[31:0];
                        end
                    end else begin
                        {HI, LO} <= prod;
                    end
`else
                    if (!is_div) {HI, LO} <= prod;
`endif
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
